// File: rtl/grant_requester_if.sv
// Job/handshake bundle between local logic, the requester and the grant controller.
// master = requester side (drives req/cancel/go/status), slave = the other side.
interface grant_requester_if #(
    parameter int PEND_W = 3
);
    logic              job_valid;
    logic              job_abort;
    logic              grant;
    logic              req;
    logic              cancel;
    logic              go;
    logic [PEND_W-1:0] pending;
    logic              done;
    logic              err_late;
    logic              err_double;
    logic              err_ovf;

    modport master (
        input  job_valid, job_abort, grant,
        output req, cancel, go, pending, done, err_late, err_double, err_ovf
    );

    modport slave (
        output job_valid, job_abort, grant,
        input  req, cancel, go, pending, done, err_late, err_double, err_ovf
    );
endinterface

// File: rtl/grant_requester.sv
// Client-side req/cancel/go/grant initiator: queues jobs, issues one req per job, times the grant.
// Latency: job_valid -> req two cycles later when idle; grant -> done next cycle. No backpressure: overflow jobs are dropped.
module grant_requester #(
    parameter int PEND_W  = 3,
    parameter int TIMEOUT = 3
) (
    input  logic                clk,
    input  logic                rst,
    grant_requester_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CANCEL,
        S_RELEASE
    } state_t;

    localparam logic [PEND_W-1:0] CAP = '1;
    localparam logic [3:0]        TMO = 4'(TIMEOUT);

    state_t            state_q, state_d;
    logic [3:0]        timer_q, timer_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              done_q, done_d;
    logic              grant_q;
    logic              err_late_q, err_double_q, err_ovf_q;
    logic              dec, inc, full, late_set, ovf_set;

    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        dec      = 1'b0;
        done_d   = 1'b0;
        late_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.job_abort) begin
                    state_d = S_CANCEL;
                    dec     = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    timer_d = 4'd1;
                end
            end
            S_WAIT: begin
                // Grant beats a same-cycle abort; timeout is checked last.
                if (bus.grant) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    dec     = 1'b1;
                end else if (bus.job_abort) begin
                    state_d = S_CANCEL;
                    dec     = 1'b1;
                end else if (timer_q == TMO) begin
                    state_d  = S_IDLE;
                    late_set = 1'b1;
                    dec      = 1'b1;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            S_CANCEL:  state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // A decrement in the same cycle frees a slot, so the job is accepted.
    always_comb begin
        full    = (pending_q == CAP) && !dec;
        inc     = bus.job_valid && !full;
        ovf_set = bus.job_valid && full;
        if (inc && !dec)
            pending_d = pending_q + 1'b1;
        else if (dec && !inc)
            pending_d = pending_q - 1'b1;
        else
            pending_d = pending_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            pending_q    <= '0;
            done_q       <= 1'b0;
            grant_q      <= 1'b0;
            err_late_q   <= 1'b0;
            err_double_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            done_q       <= done_d;
            grant_q      <= bus.grant;
            err_late_q   <= err_late_q | late_set;
            err_double_q <= err_double_q | (grant_q & bus.grant);
            err_ovf_q    <= err_ovf_q | ovf_set;
        end
    end

    assign bus.req        = (state_q == S_REQ);
    assign bus.cancel     = (state_q == S_CANCEL);
    assign bus.go         = (state_q == S_RELEASE);
    assign bus.pending    = pending_q;
    assign bus.done       = done_q;
    assign bus.err_late   = err_late_q;
    assign bus.err_double = err_double_q;
    assign bus.err_ovf    = err_ovf_q;
endmodule

// File: tb/tb_grant_requester.sv
// Bench for grant_requester: directed scenarios plus randomized traffic against a
// timeline model (req/cancel/done cycles and idle-from times) of the handshake rules.
module tb_grant_requester;
    localparam int PEND_W  = 3;
    localparam int TIMEOUT = 3;
    localparam int CAP     = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    grant_requester_if #(.PEND_W(PEND_W)) bus ();

    grant_requester #(.PEND_W(PEND_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Timeline model: absolute cycle numbers of upcoming events.
    int m_pend, m_req_at, m_cancel_at, m_done_at, m_idle_from;
    bit m_busy, m_late, m_dbl, m_ovf, m_prev_gr;

    wire [9:0] dut_vec = {bus.req, bus.cancel, bus.go, bus.done,
                          bus.err_late, bus.err_double, bus.err_ovf, bus.pending};

    function automatic logic [9:0] exp_vec();
        return {(cyc == m_req_at), (cyc == m_cancel_at), (cyc == m_cancel_at + 1),
                (cyc == m_done_at), m_late, m_dbl, m_ovf, 3'(m_pend)};
    endfunction

    task automatic model_reset();
        m_pend = 0; m_req_at = -100; m_cancel_at = -100; m_done_at = -100;
        m_idle_from = cyc; m_busy = 0; m_late = 0; m_dbl = 0; m_ovf = 0; m_prev_gr = 0;
    endtask

    task automatic model_step(input bit jv, input bit ab, input bit gr);
        int c = cyc;
        bit dec = 0;
        if (m_busy) begin
            if (c == m_req_at) begin
                if (ab) begin dec = 1; m_busy = 0; m_cancel_at = c + 1; m_idle_from = c + 3; end
            end else if (gr) begin
                dec = 1; m_busy = 0; m_done_at = c + 1; m_idle_from = c + 1;
            end else if (ab) begin
                dec = 1; m_busy = 0; m_cancel_at = c + 1; m_idle_from = c + 3;
            end else if (c == m_req_at + TIMEOUT) begin
                dec = 1; m_busy = 0; m_late = 1; m_idle_from = c + 1;
            end
        end else if (c >= m_idle_from && m_pend > 0) begin
            m_busy = 1; m_req_at = c + 1;
        end
        if (gr && m_prev_gr) m_dbl = 1;
        m_prev_gr = gr;
        if (jv) begin
            if (m_pend == CAP && !dec) m_ovf = 1;
            else m_pend++;
        end
        if (dec) m_pend--;
    endtask

    task automatic step(input bit jv, input bit ab, input bit gr);
        bus.job_valid = jv; bus.job_abort = ab; bus.grant = gr;
        model_step(jv, ab, gr);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        bus.job_valid = 0; bus.job_abort = 0; bus.grant = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.job_valid = 0; bus.job_abort = 0; bus.grant = 0;
        #2;
        rst = 1;
        #1;
        checks++;
        if (dut_vec !== 10'd0) begin errors++; $display("FAIL reset_async got %h expected %h", dut_vec, 10'd0); end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_model got %h expected %h", dut_vec, exp_vec()); end
        checks++;
        if (bus.pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d expected 0", bus.pending); end
    endtask

    task automatic test_single_job();
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL single_model k=%0d got %h expected %h", k, dut_vec, exp_vec()); end
            if (k == 1) begin checks++; if (bus.pending !== 3'd1) begin errors++; $display("FAIL single_pend1 got %0d expected 1", bus.pending); end end
            if (k == 2) begin checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL single_req got %b expected 1", bus.req); end end
            if (k == 5) begin checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL single_done got %b expected 1", bus.done); end end
            step(k == 0, 1'b0, k == 4);
        end
        checks++;
        if ({bus.pending, bus.err_late, bus.err_double, bus.err_ovf} !== 6'd0) begin
            errors++; $display("FAIL single_final got %h expected 0", {bus.pending, bus.err_late, bus.err_double, bus.err_ovf});
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL timeout_model k=%0d got %h expected %h", k, dut_vec, exp_vec()); end
            if (k == 5) begin checks++; if (bus.err_late !== 1'b0) begin errors++; $display("FAIL timeout_early got %b expected 0", bus.err_late); end end
            if (k == 6) begin checks++; if (bus.err_late !== 1'b1 || bus.pending !== 3'd0) begin errors++; $display("FAIL timeout_late got %b/%0d expected 1/0", bus.err_late, bus.pending); end end
            if (k == 7) begin checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL timeout_noreq got %b expected 0", bus.req); end end
            step(k == 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_abort();
        int dn = 0;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL abort_model k=%0d got %h expected %h", k, dut_vec, exp_vec()); end
            dn += int'(bus.done);
            if (k == 4) begin checks++; if (bus.cancel !== 1'b1 || bus.go !== 1'b0 || bus.pending !== 3'd0) begin errors++; $display("FAIL abort_cancel got c%b g%b p%0d expected c1 g0 p0", bus.cancel, bus.go, bus.pending); end end
            if (k == 5) begin checks++; if (bus.go !== 1'b1 || bus.cancel !== 1'b0) begin errors++; $display("FAIL abort_go got g%b c%b expected g1 c0", bus.go, bus.cancel); end end
            step(k == 0, k == 3, 1'b0);
        end
        checks++;
        if (dn != 0) begin errors++; $display("FAIL abort_nodone got %0d expected 0", dn); end
    endtask

    task automatic test_collision();
        int cg = 0;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL collide_model k=%0d got %h expected %h", k, dut_vec, exp_vec()); end
            cg += int'(bus.cancel) + int'(bus.go);
            if (k == 4) begin checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL collide_done got %b expected 1", bus.done); end end
            step(k == 0, k == 3, k == 3);
        end
        checks++;
        if (cg != 0) begin errors++; $display("FAIL collide_nocancel got %0d expected 0", cg); end
    endtask

    task automatic test_back_to_back();
        int  maxp = 0, dn = 0, rq = 0;
        bit  prev_req = 0, req_now;
        apply_reset();
        for (int k = 0; k < 60; k++) begin
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL b2b_model k=%0d got %h expected %h", k, dut_vec, exp_vec()); end
            if (int'(bus.pending) > maxp) maxp = int'(bus.pending);
            dn += int'(bus.done);
            rq += int'(bus.req);
            req_now = bus.req;
            step(k < 12, 1'b0, prev_req);
            prev_req = req_now;
        end
        checks++;
        if (maxp != CAP) begin errors++; $display("FAIL b2b_maxpend got %0d expected %0d", maxp, CAP); end
        checks++;
        if (bus.err_ovf !== 1'b1) begin errors++; $display("FAIL b2b_ovf got %b expected 1", bus.err_ovf); end
        checks++;
        if (dn != 10 || rq != 10) begin errors++; $display("FAIL b2b_count got done=%0d req=%0d expected 10/10", dn, rq); end
        checks++;
        if (bus.pending !== 3'd0 || bus.err_late !== 1'b0) begin errors++; $display("FAIL b2b_final got p%0d late%b expected p0 late0", bus.pending, bus.err_late); end
    endtask

    task automatic test_double();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL double_model k=%0d got %h expected %h", k, dut_vec, exp_vec()); end
            if (k == 3) begin checks++; if (bus.err_double !== 1'b0) begin errors++; $display("FAIL double_early got %b expected 0", bus.err_double); end end
            if (k == 7) begin checks++; if (bus.err_double !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL double_sticky got %b/%b expected 1/0", bus.err_double, bus.done); end end
            step(1'b0, 1'b0, k == 2 || k == 3);
        end
        apply_reset();
        checks++;
        if (bus.err_double !== 1'b0) begin errors++; $display("FAIL double_clear got %b expected 0", bus.err_double); end
    endtask

    task automatic test_reset_mid_cancel();
        apply_reset();
        for (int k = 0; k < 3; k++) step(k == 0, k == 2, 1'b0);
        checks++;
        if (bus.cancel !== 1'b1) begin errors++; $display("FAIL midrst_cancel got %b expected 1", bus.cancel); end
        #2;
        rst = 1;
        #1;
        checks++;
        if (dut_vec !== 10'd0) begin errors++; $display("FAIL midrst_outputs got %h expected %h", dut_vec, 10'd0); end
        bus.job_abort = 0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.go !== 1'b0) begin errors++; $display("FAIL midrst_go got %b expected 0", bus.go); end
        rst = 0;
        model_reset();
    endtask

    task automatic test_random();
        bit jv, ab, gr;
        int pj, pa, pg;
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_model n=%0d got %h expected %h", n, dut_vec, exp_vec()); end
            if (n % 300 == 0) begin
                pj = $urandom_range(5, 90);
                pa = $urandom_range(0, 15);
                pg = $urandom_range(5, 50);
                apply_reset();
            end
            jv = ($urandom_range(0, 99) < pj);
            ab = ($urandom_range(0, 99) < pa);
            gr = ($urandom_range(0, 99) < pg);
            step(jv, ab, gr);
        end
    endtask

    initial begin
        bus.job_valid = 0; bus.job_abort = 0; bus.grant = 0;
        model_reset();
        test_reset();
        test_single_job();
        test_timeout();
        test_abort();
        test_collision();
        test_back_to_back();
        test_double();
        test_reset_mid_cancel();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
